iic_slave_core: RTL

- I2C target (responder) at the far end of the LCD link driven by our I2C master; models the PCF8574-style backpack so the print path can be checked end to end.
- Decodes START/STOP, matches a 7-bit address, ACKs matched frames, delivers written bytes on a parallel strobe bus, and shifts out a host-supplied byte on reads.
- Open-drain SDA via output-enable; never drives SCL (no clock stretching).

---
 rtl/iic_slave_core.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/iic_slave_core.sv
// rtl/iic_slave_core.sv - I2C target with 7-bit address match, byte write strobe and host-fed read data
module iic_slave_core #(
    parameter logic [6:0] ADDR        = 7'h27,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_i2c_scl,
    input  logic       i_i2c_sda,
    output logic       o_i2c_sda_oe,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_req,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_d, sda_d, scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t     state, state_nxt;
    logic [7:0] shreg, shreg_nxt, txsh, txsh_nxt, rx_data, rx_data_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       full, full_nxt, rw, rw_nxt, oe, oe_nxt;
    logic       rx_valid, rx_valid_nxt, tx_req, tx_req_nxt, busy, busy_nxt;
    logic       load_tx;

    // Synchronizers reset to the idle-bus level so reset release never looks like START/STOP
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_i2c_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_i2c_sda};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            shreg    <= 8'h00;
            txsh     <= 8'h00;
            rx_data  <= 8'h00;
            cnt      <= 3'd0;
            full     <= 1'b0;
            rw       <= 1'b0;
            oe       <= 1'b0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            txsh     <= txsh_nxt;
            rx_data  <= rx_data_nxt;
            cnt      <= cnt_nxt;
            full     <= full_nxt;
            rw       <= rw_nxt;
            oe       <= oe_nxt;
            rx_valid <= rx_valid_nxt;
            tx_req   <= tx_req_nxt;
            busy     <= busy_nxt;
        end
    end

    // full marks "8 bits sampled, act on next SCL fall"; in READ_ACK it marks "master ACKed"
    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        txsh_nxt     = txsh;
        rx_data_nxt  = rx_data;
        cnt_nxt      = cnt;
        full_nxt     = full;
        rw_nxt       = rw;
        oe_nxt       = oe;
        rx_valid_nxt = 1'b0;
        tx_req_nxt   = 1'b0;
        busy_nxt     = busy;
        load_tx      = 1'b0;

        if (start_det) begin
            state_nxt = S_ADDR;
            cnt_nxt   = 3'd0;
            full_nxt  = 1'b0;
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b0;
        end else if (stop_det) begin
            state_nxt = S_IDLE;
            cnt_nxt   = 3'd0;
            full_nxt  = 1'b0;
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_WRITE: begin
                    if (scl_rise) begin
                        shreg_nxt = {shreg[6:0], sda_s};
                        cnt_nxt   = cnt + 3'd1;
                        if (cnt == 3'd7) full_nxt = 1'b1;
                    end else if (scl_fall && full) begin
                        full_nxt = 1'b0;
                        if (state == S_WRITE) begin
                            rx_data_nxt  = shreg;
                            rx_valid_nxt = 1'b1;
                            oe_nxt       = 1'b1;
                            state_nxt    = S_WRITE_ACK;
                        end else if (shreg[7:1] == ADDR && shreg[7:1] != 7'd0) begin
                            rw_nxt    = shreg[0];
                            oe_nxt    = 1'b1;
                            busy_nxt  = 1'b1;
                            state_nxt = S_ADDR_ACK;
                        end else begin
                            state_nxt = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw) begin
                            load_tx = 1'b1;
                        end else begin
                            oe_nxt    = 1'b0;
                            state_nxt = S_WRITE;
                        end
                    end
                end
                S_WRITE_ACK: begin
                    if (scl_fall) begin
                        oe_nxt    = 1'b0;
                        state_nxt = S_WRITE;
                    end
                end
                S_READ: begin
                    if (scl_fall) begin
                        if (cnt == 3'd7) begin
                            oe_nxt    = 1'b0;
                            cnt_nxt   = 3'd0;
                            full_nxt  = 1'b0;
                            state_nxt = S_READ_ACK;
                        end else begin
                            cnt_nxt  = cnt + 3'd1;
                            txsh_nxt = {txsh[6:0], 1'b0};
                            oe_nxt   = ~txsh[6];
                        end
                    end
                end
                S_READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) state_nxt = S_IGNORE;
                        else       full_nxt  = 1'b1;
                    end else if (scl_fall && full) begin
                        full_nxt = 1'b0;
                        load_tx  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (load_tx) begin
            txsh_nxt   = i_tx_data;
            oe_nxt     = ~i_tx_data[7];
            tx_req_nxt = 1'b1;
            cnt_nxt    = 3'd0;
            state_nxt  = S_READ;
        end
    end

    assign o_i2c_sda_oe = oe;
    assign o_rx_data    = rx_data;
    assign o_rx_valid   = rx_valid;
    assign o_tx_req     = tx_req;
    assign o_busy       = busy;

endmodule
